// File: rtl/k_sync_fifo_ctrl.sv
// k_sync_fifo_ctrl: single-clock FIFO pointer/flag controller for an external dual-port RAM.
// Flags decode registered state only; ovf/udf are sticky until err_clr.
module k_sync_fifo_ctrl #(
    parameter int unsigned addr_size  = 4,
    parameter int unsigned afull_lvl  = 12,
    parameter int unsigned aempty_lvl = 2
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 wput,
    input  logic                 rget,
    input  logic                 err_clr,
    output logic [addr_size-1:0] waddr,
    output logic [addr_size-1:0] raddr,
    output logic                 wfull,
    output logic                 rempty,
    output logic                 wafull,
    output logic                 raempty,
    output logic [addr_size:0]   level,
    output logic                 ovf,
    output logic                 udf
);
    localparam int unsigned pw = addr_size + 1;
    localparam logic [addr_size:0] one_v    = pw'(1);
    localparam logic [addr_size:0] afull_v  = pw'(afull_lvl);
    localparam logic [addr_size:0] aempty_v = pw'(aempty_lvl);

    logic [addr_size:0] wptr_q, wptr_d;
    logic [addr_size:0] rptr_q, rptr_d;
    logic [addr_size:0] level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               do_w, do_r;

    // Full when the pointers differ only in the wrap bit.
    always_comb begin
        rempty = (wptr_q == rptr_q);
        wfull  = (wptr_q[addr_size] != rptr_q[addr_size]) &&
                 (wptr_q[addr_size-1:0] == rptr_q[addr_size-1:0]);
        do_w   = wput && !wfull;
        do_r   = rget && !rempty;
    end

    always_comb begin
        wptr_d  = do_w ? wptr_q + one_v : wptr_q;
        rptr_d  = do_r ? rptr_q + one_v : rptr_q;
        level_d = level_q;
        unique case ({do_w, do_r})
            2'b10:   level_d = level_q + one_v;
            2'b01:   level_d = level_q - one_v;
            default: level_d = level_q;
        endcase
        // A new error on the same edge as err_clr keeps the bit set.
        ovf_d = (ovf_q && !err_clr) || (wput && wfull);
        udf_d = (udf_q && !err_clr) || (rget && rempty);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_comb begin
        waddr   = wptr_q[addr_size-1:0];
        raddr   = rptr_q[addr_size-1:0];
        level   = level_q;
        wafull  = (level_q >= afull_v);
        raempty = (level_q <= aempty_v);
        ovf     = ovf_q;
        udf     = udf_q;
    end

    always_ff @(posedge wclk) begin
        if (!wrst) begin
            a_level : assert (level_q == wptr_q - rptr_q);
            a_flags : assert (!(wfull && rempty));
        end
    end

endmodule

// File: tb/tb_k_sync_fifo_ctrl.sv
// Randomized and directed bench for k_sync_fifo_ctrl against a queue-based FIFO model.
// The bench owns the RAM so data ordering through waddr/raddr is checked end to end.
module tb_k_sync_fifo_ctrl;
    localparam int aw = 4;
    localparam int depth = 16;
    localparam int afull = 12;
    localparam int aempty = 2;

    logic          wclk = 1'b0;
    logic          wrst, wput, rget, err_clr;
    logic [aw-1:0] waddr, raddr;
    logic          wfull, rempty, wafull, raempty, ovf, udf;
    logic [aw:0]   level;
    logic [7:0]    wdata;
    logic [7:0]    mem [depth];
    logic [7:0]    rdata;

    int nvec = 0;
    int nerr = 0;

    // Reference model state.
    logic [7:0] q[$];
    int         wcnt, rcnt;
    bit         movf, mudf;

    k_sync_fifo_ctrl #(
        .addr_size (aw),
        .afull_lvl (afull),
        .aempty_lvl(aempty)
    ) dut (
        .wclk   (wclk),
        .wrst   (wrst),
        .wput   (wput),
        .rget   (rget),
        .err_clr(err_clr),
        .waddr  (waddr),
        .raddr  (raddr),
        .wfull  (wfull),
        .rempty (rempty),
        .wafull (wafull),
        .raempty(raempty),
        .level  (level),
        .ovf    (ovf),
        .udf    (udf)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) if (wput && !wfull) mem[waddr] <= wdata;
    assign rdata = mem[raddr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("level",   32'(level),   32'(n));
        chk("rempty",  32'(rempty),  32'(n == 0));
        chk("wfull",   32'(wfull),   32'(n == depth));
        chk("wafull",  32'(wafull),  32'(n >= afull));
        chk("raempty", 32'(raempty), 32'(n <= aempty));
        chk("waddr",   32'(waddr),   32'(wcnt % depth));
        chk("raddr",   32'(raddr),   32'(rcnt % depth));
        chk("ovf",     32'(ovf),     32'(movf));
        chk("udf",     32'(udf),     32'(mudf));
        if (n > 0) chk("rdata", 32'(rdata), 32'(q[0]));
    endtask

    task automatic model_reset();
        q.delete();
        wcnt = 0;
        rcnt = 0;
        movf = 0;
        mudf = 0;
    endtask

    // Inputs applied just after an edge; model advances on the next edge, then checked.
    task automatic step(input bit p, input bit g, input bit c, input logic [7:0] d);
        bit full, empty;
        wput = p;
        rget = g;
        err_clr = c;
        wdata = d;
        @(posedge wclk);
        full  = (q.size() == depth);
        empty = (q.size() == 0);
        if (c) begin
            movf = 0;
            mudf = 0;
        end
        if (p && full) movf = 1;
        if (g && empty) mudf = 1;
        if (g && !empty) begin
            void'(q.pop_front());
            rcnt++;
        end
        if (p && !full) begin
            q.push_back(d);
            wcnt++;
        end
        #1;
        check_all();
    endtask

    task automatic async_reset();
        wput = 0;
        rget = 0;
        err_clr = 0;
        #2;
        wrst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge wclk);
        wrst = 1'b0;
        @(posedge wclk);
        #1;
        check_all();
    endtask

    initial begin
        wrst = 1'b1;
        wput = 0;
        rget = 0;
        err_clr = 0;
        wdata = '0;
        model_reset();
        #3;
        check_all();
        @(negedge wclk);
        wrst = 1'b0;
        @(posedge wclk);
        #1;
        check_all();

        // Fill, overflow, drain, underflow.
        for (int i = 0; i < depth; i++) step(1, 0, 0, 8'(i));
        step(1, 0, 0, 8'hAA);
        for (int i = 0; i < depth; i++) step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);

        // Simultaneous put+get at full and at empty.
        for (int i = 0; i < depth; i++) step(1, 0, 0, 8'(8'h40 + i));
        step(1, 1, 0, 8'hEE);
        step(0, 0, 1, 8'h00);
        while (q.size() > 0) step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h5A);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);

        // Steady state at level 5 across pointer wraps.
        while (q.size() < 5) step(1, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1, 1, 0, 8'($urandom));

        // Reset mid-burst at level 7.
        while (q.size() < 7) step(1, 0, 0, 8'($urandom));
        async_reset();

        // err_clr concurrent with a new overflow keeps ovf set; same for udf.
        step(0, 1, 1, 8'h00);
        for (int i = 0; i < depth; i++) step(1, 0, 0, 8'($urandom));
        step(1, 0, 0, 8'h11);
        step(1, 0, 1, 8'h22);
        step(0, 0, 1, 8'h00);

        // Random traffic with varying bias toward filling or draining.
        for (int i = 0; i < 800; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 70 : 30;
            step(($urandom_range(99) < bias), ($urandom_range(99) >= bias - 10),
                 ($urandom_range(99) < 5), 8'($urandom));
            if (i == 400) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
